piso_chain_serializer: RTL and testbench
========================================

// Module: piso_chain_serializer
// PURPOSE
//  Parametrised parallel-to-serial converter with a one-word staging buffer in front of the shift register.
//  The next word can be loaded while the current word is still shifting.
//  Serialises WORD_W-bit words on Sclk, MSB- or LSB-first, gated by Frame.
//  Can run back-to-back frames (AUTO_CHAIN) with no idle cycle between them.
//  Sits between the parallel datapath and the serial output pin.
// PARAMETERS
//  WORD_W     40  bits per word; legal range 2..64
//  MSB_FIRST  1   1: bit WORD_W-1 is sent first; 0: bit 0 is sent first
//  AUTO_CHAIN 0   1: a staged word starts on the edge right after the last bit; 0: it waits in IDLE for Frame
// PORTS
//  Sclk        in   1       clock; every register updates on the falling edge
//  Clear       in   1       synchronous, active-high reset
//  p2s_enable  in   1       load request: Shifted is written into the staging buffer
//  Shifted     in   WORD_W  parallel word to load
//  Frame       in   1       start request, sampled in IDLE
//  Serial_out  out  1       serial data
//  OutReady    out  1       1 while Serial_out carries a valid bit
//  Busy        out  1       1 in SHIFT state
//  Space       out  1       staging buffer is empty
//  FrameStart  out  1       1-cycle pulse on the edge that drives the first bit of a word
//  Overrun     out  1       1-cycle pulse: a load was dropped because the buffer was full
//  Underrun    out  1       1-cycle pulse: a frame ended with Frame=1 but no word was staged
// BEHAVIOUR
//  Clear (on the falling edge where Clear=1)
//   - All outputs go to 0 except Space, which goes to 1.
//   - The staging buffer is emptied, the state goes to IDLE and any frame in flight is aborted.
//   - Clear takes priority over every other input.
//  Staging buffer
//   - p2s_enable=1 is accepted when the buffer is empty, or when the buffer is being moved into the shift register on this same edge.
//   - An accepted load sets staged-valid and clears Space.
//   - Otherwise the load is ignored, the staged word is kept unchanged, and Overrun pulses.
//  Bit counter
//   - Width $clog2(WORD_W).
//   - Loaded with WORD_W-1 on the first-bit edge; counts down to 0.
//  State IDLE
//   - Serial_out=0, OutReady=0, Busy=0.
//   - If Frame=1 and staged-valid=1 on an edge:
//     - the staged word moves to the shift register and staged-valid clears;
//     - on that same edge Serial_out takes the first bit, OutReady=1, FrameStart=1, Busy=1, and the state goes to SHIFT.
//   - Latency from the Frame sample to the first bit is 0 edges: the bit appears on the edge that samples Frame.
//   - If Frame=1 and the buffer is empty, stay in IDLE with no flag.
//  State SHIFT
//   - Each edge outputs the next bit in the MSB_FIRST order, with OutReady=1, and decrements the counter.
//   - A word occupies exactly WORD_W consecutive edges.
//  Edge after the last bit (counter was 0)
//   - If AUTO_CHAIN=1 and staged-valid=1: the next word starts immediately (FrameStart=1, OutReady stays 1, no gap).
//   - Otherwise: go to IDLE with Serial_out=0, OutReady=0, Busy=0.
//     - In the AUTO_CHAIN=0 case, if Frame=1 and a word is staged, that word starts on the following IDLE edge.
//   - If Frame=1 on this edge and the buffer is empty: Underrun pulses.
//  Frame is ignored while in SHIFT; frames cannot be aborted except by Clear.
//  Simultaneous load and word start on one edge: the old staged word is shifted out, the new word is staged, and Space stays 0.
//  Clear mid-frame: Serial_out=0 and OutReady=0 on that same edge; the remaining bits are lost.
// TESTING
//  1. Reset, WORD_W=40, MSB_FIRST=1
//     - Stimulus: load 40'hA5_0000_0001, then Frame=1.
//     - Required: bits 1,0,1,0,0,1,0,1,... ending in 1 over 40 edges, OutReady=1 for exactly 40 edges, then 0.
//  2. MSB_FIRST=0
//     - Stimulus: load 40'h1, then Frame=1.
//     - Required: first Serial_out=1, then 39 zeros; FrameStart pulses once.
//  3. AUTO_CHAIN=1
//     - Stimulus: load W0; Frame; load W1 during bit 5 of W0.
//     - Required: 80 consecutive OutReady=1 edges, FrameStart on edges 0 and 40, Space=1 after edge 40.
//  4. Overrun
//     - Stimulus: with a word staged and no start, assert p2s_enable.
//     - Required: Overrun=1 for one cycle; the original staged word is still the one shifted out.
//  5. Underrun
//     - Stimulus: AUTO_CHAIN=0, Frame held 1, only one word loaded.
//     - Required: Underrun pulses on the edge after the last bit; the state returns to IDLE.
//  6. Clear at bit 17
//     - Required: Serial_out, OutReady and Busy are 0 on that edge; Space=1; a new load plus Frame starts a complete 40-bit frame.

Source files
------------

// File: rtl/piso_chain_serializer.sv
// Parallel-to-serial converter with a one-word staging buffer ahead of the shift register.
// All state updates on the falling edge of i_sclk; staged words can optionally chain back-to-back.
module piso_chain_serializer #(
    parameter int unsigned WORD_W     = 40,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          AUTO_CHAIN = 1'b0
) (
    input  logic              i_sclk,
    input  logic              i_clear,
    input  logic              i_p2s_enable,
    input  logic [WORD_W-1:0] i_shifted,
    input  logic              i_frame,
    output logic              o_serial_out,
    output logic              o_out_ready,
    output logic              o_busy,
    output logic              o_space,
    output logic              o_frame_start,
    output logic              o_overrun,
    output logic              o_underrun
);
    localparam int unsigned     CntW    = $clog2(WORD_W);
    localparam logic [CntW-1:0] CntLast = CntW'(WORD_W - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e            r_state, w_state_d;
    logic [WORD_W-1:0] r_stage, w_stage_d;
    logic [WORD_W-1:0] r_shreg, w_shreg_d;
    logic [CntW-1:0]   r_cnt, w_cnt_d;
    logic              r_valid, w_valid_d;
    logic              r_sout, w_sout_d;
    logic              r_ready, w_ready_d;
    logic              r_fstart, w_fstart_d;
    logic              r_ovr, w_ovr_d;
    logic              r_udr, w_udr_d;
    logic              w_last;
    logic              w_start;
    logic              w_accept;

    // The bit presented next and the word left after presenting it, in the configured order.
    function automatic logic head_bit(input logic [WORD_W-1:0] w);
        return MSB_FIRST ? w[WORD_W-1] : w[0];
    endfunction

    function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    always_comb begin
        w_last   = (r_cnt == '0);
        w_start  = r_valid && ((r_state == StIdle && i_frame) ||
                               (r_state == StShift && w_last && AUTO_CHAIN));
        // A full buffer can still take a load on the edge that empties it into the shifter.
        w_accept = i_p2s_enable && (!r_valid || w_start);

        w_state_d  = r_state;
        w_shreg_d  = r_shreg;
        w_cnt_d    = r_cnt;
        w_sout_d   = 1'b0;
        w_ready_d  = 1'b0;
        w_fstart_d = 1'b0;
        w_udr_d    = 1'b0;
        w_ovr_d    = i_p2s_enable && !w_accept;
        w_stage_d  = w_accept ? i_shifted : r_stage;
        w_valid_d  = w_accept ? 1'b1 : (w_start ? 1'b0 : r_valid);

        if (w_start) begin
            w_state_d  = StShift;
            w_sout_d   = head_bit(r_stage);
            w_shreg_d  = advance(r_stage);
            w_cnt_d    = CntLast;
            w_ready_d  = 1'b1;
            w_fstart_d = 1'b1;
        end else if (r_state == StShift) begin
            if (!w_last) begin
                w_sout_d  = head_bit(r_shreg);
                w_shreg_d = advance(r_shreg);
                w_cnt_d   = r_cnt - 1'b1;
                w_ready_d = 1'b1;
            end else begin
                w_state_d = StIdle;
                w_udr_d   = i_frame && !r_valid;
            end
        end
    end

    always_ff @(negedge i_sclk) begin
        if (i_clear) begin
            r_state  <= StIdle;
            r_stage  <= '0;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_sout   <= 1'b0;
            r_ready  <= 1'b0;
            r_fstart <= 1'b0;
            r_ovr    <= 1'b0;
            r_udr    <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_stage  <= w_stage_d;
            r_shreg  <= w_shreg_d;
            r_cnt    <= w_cnt_d;
            r_valid  <= w_valid_d;
            r_sout   <= w_sout_d;
            r_ready  <= w_ready_d;
            r_fstart <= w_fstart_d;
            r_ovr    <= w_ovr_d;
            r_udr    <= w_udr_d;
        end
    end

    assign o_serial_out  = r_sout;
    assign o_out_ready   = r_ready;
    assign o_busy        = (r_state == StShift);
    assign o_space       = !r_valid;
    assign o_frame_start = r_fstart;
    assign o_overrun     = r_ovr;
    assign o_underrun    = r_udr;

endmodule

// File: tb/tb_piso_chain_serializer.sv
// Bench for piso_chain_serializer: two instances (MSB-first/no chain, LSB-first/auto chain)
// share stimulus; a scoreboard checks every presented bit, directed checks cover the flags.
module tb_piso_chain_serializer;
    localparam int unsigned W = 40;

    logic         clk = 1'b1;
    logic         clear;
    logic         p2s;
    logic [W-1:0] shifted;
    logic         frame;

    logic a_sout, a_ready, a_busy, a_space, a_fs, a_ovr, a_udr;
    logic b_sout, b_ready, b_busy, b_space, b_fs, b_ovr, b_udr;

    int n_tests = 0;
    int n_fail  = 0;
    logic mon_en = 1'b0;

    logic qa_bit[$], qa_first[$], qb_bit[$], qb_first[$];

    always #5 clk = ~clk;

    piso_chain_serializer #(.WORD_W(W), .MSB_FIRST(1'b1), .AUTO_CHAIN(1'b0)) dut_a (
        .i_sclk(clk), .i_clear(clear), .i_p2s_enable(p2s), .i_shifted(shifted),
        .i_frame(frame), .o_serial_out(a_sout), .o_out_ready(a_ready), .o_busy(a_busy),
        .o_space(a_space), .o_frame_start(a_fs), .o_overrun(a_ovr), .o_underrun(a_udr)
    );

    piso_chain_serializer #(.WORD_W(W), .MSB_FIRST(1'b0), .AUTO_CHAIN(1'b1)) dut_b (
        .i_sclk(clk), .i_clear(clear), .i_p2s_enable(p2s), .i_shifted(shifted),
        .i_frame(frame), .o_serial_out(b_sout), .o_out_ready(b_ready), .o_busy(b_busy),
        .o_space(b_space), .o_frame_start(b_fs), .o_overrun(b_ovr), .o_underrun(b_udr)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns just after the falling edge's results are visible.
    task automatic edge_step();
        @(negedge clk);
        @(posedge clk);
    endtask

    // Expected stream of a word: A sends bit W-1 first, B sends bit 0 first.
    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < int'(W); i++) begin
            qa_bit.push_back(w[W-1-i]);
            qa_first.push_back(i == 0);
            qb_bit.push_back(w[i]);
            qb_first.push_back(i == 0);
        end
    endtask

    task automatic load(input logic [W-1:0] w);
        shifted = w;
        p2s     = 1'b1;
        push_word(w);
        edge_step();
        p2s     = 1'b0;
    endtask

    // Hold Frame until both instances are idle with an empty buffer.
    task automatic drain();
        int guard = 0;
        frame = 1'b1;
        while (!(a_space && b_space && !a_busy && !b_busy && !a_ready && !b_ready)
               && guard < 300) begin
            edge_step();
            guard++;
        end
        frame = 1'b0;
        if (guard >= 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d edges required fewer than 300", guard);
        end
    endtask

    task automatic send_frame(input string tag, input logic [W-1:0] w);
        int run_a = 0;
        int run_b = 0;
        load(w);
        chk1({tag, "_a_space_loaded"}, a_space, 1'b0);
        chk1({tag, "_b_space_loaded"}, b_space, 1'b0);
        frame = 1'b1;
        edge_step();
        frame = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            if (a_ready) run_a++;
            if (b_ready) run_b++;
            edge_step();
        end
        chkn({tag, "_a_ready_len"}, run_a, W);
        chkn({tag, "_b_ready_len"}, run_b, W);
        chk1({tag, "_a_ready_end"}, a_ready, 1'b0);
        chk1({tag, "_b_ready_end"}, b_ready, 1'b0);
        chk1({tag, "_a_busy_end"}, a_busy, 1'b0);
        chk1({tag, "_b_space_end"}, b_space, 1'b1);
    endtask

    // Scoreboard monitor: pops one expected bit per OutReady edge.
    always @(posedge clk) begin
        if (mon_en) begin
            if (a_ready) begin
                if (qa_bit.size() == 0) begin
                    chkn("a_unexpected_bit_queue", 0, 1);
                end else begin
                    chk1("a_serial", a_sout, qa_bit.pop_front());
                    chk1("a_frame_start", a_fs, qa_first.pop_front());
                end
            end else begin
                chk1("a_idle_serial", a_sout, 1'b0);
                chk1("a_idle_frame_start", a_fs, 1'b0);
            end
            if (b_ready) begin
                if (qb_bit.size() == 0) begin
                    chkn("b_unexpected_bit_queue", 0, 1);
                end else begin
                    chk1("b_serial", b_sout, qb_bit.pop_front());
                    chk1("b_frame_start", b_fs, qb_first.pop_front());
                end
            end else begin
                chk1("b_idle_serial", b_sout, 1'b0);
                chk1("b_idle_frame_start", b_fs, 1'b0);
            end
        end
    end

    initial begin
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        int           run_b;
        int           k;

        clear   = 1'b1;
        p2s     = 1'b0;
        frame   = 1'b0;
        shifted = '0;
        edge_step();
        edge_step();
        chk1("rst_a_serial", a_sout, 1'b0);
        chk1("rst_a_ready", a_ready, 1'b0);
        chk1("rst_a_busy", a_busy, 1'b0);
        chk1("rst_a_space", a_space, 1'b1);
        chk1("rst_a_fstart", a_fs, 1'b0);
        chk1("rst_a_overrun", a_ovr, 1'b0);
        chk1("rst_a_underrun", a_udr, 1'b0);
        chk1("rst_b_ready", b_ready, 1'b0);
        chk1("rst_b_space", b_space, 1'b1);
        chk1("rst_b_busy", b_busy, 1'b0);
        clear  = 1'b0;
        mon_en = 1'b1;
        edge_step();

        send_frame("t1", 40'hA5_0000_0001);
        send_frame("t2", 40'h00_0000_0001);

        // Auto chain: W1 loaded mid-word; B chains, A parks W1 in the buffer.
        w0 = 40'h3C_DEAD_BEEF;
        w1 = 40'hC3_1234_5678;
        load(w0);
        frame = 1'b1;
        edge_step();
        frame = 1'b0;
        run_b = 0;
        for (int i = 0; i < 80; i++) begin
            if (b_ready) run_b++;
            if (i == 0 || i == 40) chk1("t3_b_fstart_edge", b_fs, 1'b1);
            if (i == 40) begin
                chk1("t3_b_space_after_40", b_space, 1'b1);
                chk1("t3_a_ready_after_40", a_ready, 1'b0);
                chk1("t3_a_space_w1_staged", a_space, 1'b0);
            end
            if (i == 5) begin
                shifted = w1;
                p2s     = 1'b1;
                push_word(w1);
            end else begin
                p2s = 1'b0;
            end
            edge_step();
        end
        chkn("t3_b_ready_run", run_b, 80);
        chk1("t3_b_ready_end", b_ready, 1'b0);
        drain();

        // Overrun, then a load on the same edge a staged word starts.
        load(40'h11_2233_4455);
        shifted = 40'hFF_FFFF_FFFF;
        p2s     = 1'b1;
        edge_step();
        p2s = 1'b0;
        chk1("t4_a_overrun", a_ovr, 1'b1);
        chk1("t4_b_overrun", b_ovr, 1'b1);
        edge_step();
        chk1("t4_a_overrun_pulse", a_ovr, 1'b0);
        chk1("t4_a_space_kept", a_space, 1'b0);
        shifted = 40'h66_7788_99AA;
        p2s     = 1'b1;
        frame   = 1'b1;
        push_word(40'h66_7788_99AA);
        edge_step();
        p2s   = 1'b0;
        frame = 1'b0;
        chk1("t4_a_sim_start", a_busy, 1'b1);
        chk1("t4_a_sim_space", a_space, 1'b0);
        chk1("t4_b_sim_space", b_space, 1'b0);
        chk1("t4_a_sim_no_ovr", a_ovr, 1'b0);
        drain();

        // Underrun: Frame held across a single word.
        load(40'h0F_F0F0_0F0F);
        frame = 1'b1;
        edge_step();
        repeat (W - 1) edge_step();
        chk1("t5_a_udr_not_early", a_udr, 1'b0);
        edge_step();
        chk1("t5_a_underrun", a_udr, 1'b1);
        chk1("t5_b_underrun", b_udr, 1'b1);
        chk1("t5_a_busy_idle", a_busy, 1'b0);
        chk1("t5_a_ready_idle", a_ready, 1'b0);
        frame = 1'b0;
        edge_step();
        chk1("t5_a_udr_pulse", a_udr, 1'b0);

        // Clear on the edge that would present bit 17.
        load(40'hAB_CDEF_0123);
        frame = 1'b1;
        edge_step();
        frame = 1'b0;
        repeat (16) edge_step();
        clear = 1'b1;
        edge_step();
        clear = 1'b0;
        qa_bit.delete();
        qa_first.delete();
        qb_bit.delete();
        qb_first.delete();
        chk1("t6_a_serial", a_sout, 1'b0);
        chk1("t6_a_ready", a_ready, 1'b0);
        chk1("t6_a_busy", a_busy, 1'b0);
        chk1("t6_a_space", a_space, 1'b1);
        chk1("t6_b_ready", b_ready, 1'b0);
        chk1("t6_b_busy", b_busy, 1'b0);
        send_frame("t6_after", 40'h5A_5A5A_A5A5);

        // Random words, optionally with a second word loaded mid-frame.
        for (int r = 0; r < 10; r++) begin
            w0[31:0]  = $urandom();
            w0[39:32] = 8'($urandom());
            w1[31:0]  = $urandom();
            w1[39:32] = 8'($urandom());
            k         = int'($urandom_range(2, 37));
            load(w0);
            frame = 1'b1;
            edge_step();
            frame = 1'b0;
            repeat (k) edge_step();
            if ($urandom_range(0, 1) == 1) load(w1);
            drain();
            repeat ($urandom_range(0, 3)) edge_step();
        end

        edge_step();
        chkn("end_a_queue_empty", qa_bit.size(), 0);
        chkn("end_b_queue_empty", qb_bit.size(), 0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
